// File: rtl/operand_scoreboard_pkg.sv
// Shared register-file constants for the TINY pipeline operand interlock.
// Also used by the operand fetch unit and the register write bank.
package operand_scoreboard_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned RA_REG   = 15;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned PTR_W    = 2;
  localparam int unsigned CNT_W    = 3;

  function automatic logic [NUM_REGS-1:0] regOnehot(input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] vec;
    vec       = '0;
    vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/operand_scoreboard_inflight_fifo.sv
// In-order FIFO of destination registers for in-flight writers.
// Same-edge order of effect: pop head, then trim youngest on flush, then push.
module operand_scoreboard_inflight_fifo
  import operand_scoreboard_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [ADDR_W-1:0]       pushDst,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [2:0]              flushCount,
  output logic [DEPTH-1:0]        validVec,
  output logic [DEPTH*ADDR_W-1:0] dstVec,
  output logic [ADDR_W-1:0]       headDst,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic                    empty
);

  logic [DEPTH-1:0]  validQ, validD;
  logic [ADDR_W-1:0] dstQ [DEPTH];
  logic [ADDR_W-1:0] dstD [DEPTH];
  logic [PTR_W-1:0]  headQ, headD, tailQ, tailD;
  logic [CNT_W-1:0]  countQ, countD;
  logic [CNT_W-1:0]  cntAfterPop, trim;

  always_comb begin
    validD      = validQ;
    dstD        = dstQ;
    headD       = headQ;
    tailD       = tailQ;
    countD      = countQ;
    cntAfterPop = countQ;
    trim        = '0;

    if (pop && countQ != '0) begin
      validD[headQ] = 1'b0;
      headD         = headQ + PTR_W'(1);
      countD        = countQ - CNT_W'(1);
    end
    cntAfterPop = countD;

    if (flush) begin
      trim = (flushCount < cntAfterPop) ? flushCount : cntAfterPop;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < trim) begin
        validD[tailQ - PTR_W'(i + 1)] = 1'b0;
      end
    end
    // A full trim (trim == DEPTH) wraps the tail back onto itself.
    tailD  = tailQ - trim[PTR_W-1:0];
    countD = countD - trim;

    if (push && !flush && countD != CNT_W'(DEPTH)) begin
      validD[tailD] = 1'b1;
      dstD[tailD]   = pushDst;
      tailD         = tailD + PTR_W'(1);
      countD        = countD + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validQ <= '0;
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dstQ[i] <= '0;
      end
    end else begin
      validQ <= validD;
      headQ  <= headD;
      tailQ  <= tailD;
      countQ <= countD;
      dstQ   <= dstD;
    end
  end

  always_comb begin
    dstVec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dstVec[i*ADDR_W +: ADDR_W] = dstQ[i];
    end
  end

  assign validVec = validQ;
  assign headDst  = dstQ[headQ];
  assign count    = countQ;
  assign full     = (countQ == CNT_W'(DEPTH));
  assign empty    = (countQ == '0);

endmodule

// File: rtl/operand_scoreboard.sv
// RAW interlock between operand fetch and write-back: tracks pending register writes,
// stalls dependent issue until the producer retires, and trims younger writers on flush.
module operand_scoreboard
  import operand_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                issueValid,
  input  logic [ADDR_W-1:0]   issueSr1Addr,
  input  logic [ADDR_W-1:0]   issueSr2Addr,
  input  logic                issueUsesSr1,
  input  logic                issueUsesSr2,
  input  logic                issueIsWb,
  input  logic                issueIsCall,
  input  logic [ADDR_W-1:0]   issueRd,
  input  logic                wbValid,
  input  logic [ADDR_W-1:0]   wbAddr,
  input  logic                flush,
  input  logic [2:0]          flushCount,
  output logic                stall,
  output logic                issueFire,
  output logic [NUM_REGS-1:0] busyMask,
  output logic [2:0]          count,
  output logic                full,
  output logic                empty,
  output logic                wbError
);

  logic [DEPTH-1:0]        validVec;
  logic [DEPTH*ADDR_W-1:0] dstVec;
  logic [ADDR_W-1:0]       headDst;
  logic [ADDR_W-1:0]       pushDst;
  logic                    pushEn;
  logic                    wbErrorQ;

  assign pushDst = issueIsCall ? ADDR_W'(RA_REG) : issueRd;
  assign pushEn  = issueFire & issueIsWb;

  operand_scoreboard_inflight_fifo uFifo (
    .clk        (clk),
    .rst        (rst),
    .push       (pushEn),
    .pushDst    (pushDst),
    .pop        (wbValid),
    .flush      (flush),
    .flushCount (flushCount),
    .validVec   (validVec),
    .dstVec     (dstVec),
    .headDst    (headDst),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  // Busy comes from registered entries only, so the write-back cycle still reads busy.
  always_comb begin
    busyMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (validVec[i]) begin
        busyMask = busyMask | regOnehot(dstVec[i*ADDR_W +: ADDR_W]);
      end
    end
  end

  // Full stalls even when write-back pops this cycle.
  assign stall = issueValid & (full
                               | (issueUsesSr1 & busyMask[issueSr1Addr])
                               | (issueUsesSr2 & busyMask[issueSr2Addr]));
  assign issueFire = issueValid & ~stall & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbErrorQ <= 1'b0;
    end else if (wbValid && (empty || wbAddr != headDst)) begin
      wbErrorQ <= 1'b1;
    end
  end

  assign wbError = wbErrorQ;

endmodule
